// File: rtl/fast_dispatch.sv
// fast_dispatch: in-order decode/dispatch stage feeding fast_core.
//   Buffers fetched words in a DEPTH-entry FIFO and decodes the head
//   (R-type, addi, beq/bne, lw). It tracks in-flight destinations in a
//   32-entry pending scoreboard and issues at most one instruction per cycle.
//   Dispatch is held while a branch is unresolved. The FIFO is flushed on a
//   taken branch or on recovery.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   fetch_instr/valid/ready instruction input handshake (ready = !full)
//   instr_out, instr_valid  registered dispatch word and one-cycle pulse
//   src1/src2/dest_index    {1'b0, reg} operand indices of the dispatched word
//   src1_valid, src2_valid  operands ready (always 1 on a dispatch)
//   is_branch, is_load      class of the dispatched word
//   result_valid/index      core writeback (clears pending)
//   load_wb_valid/index     load unit writeback (clears pending)
//   branch_resolved/taken   branch outcome from the core
//   recovery_trigger        global flush
//   redirect                pulse: taken branch flushed the FIFO
//   illegal_instr           pulse: unsupported opcode dropped
//   fifo_count              FIFO occupancy
module fast_dispatch #(
    parameter int DEPTH      = 8,
    parameter int BR_TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [31:0]              fetch_instr,
    input  logic                     fetch_valid,
    output logic                     fetch_ready,
    output logic [31:0]              instr_out,
    output logic                     instr_valid,
    output logic [5:0]               src1_index,
    output logic [5:0]               src2_index,
    output logic [5:0]               dest_index,
    output logic                     src1_valid,
    output logic                     src2_valid,
    output logic                     is_branch,
    output logic                     is_load,
    input  logic                     result_valid,
    input  logic [5:0]               result_index,
    input  logic                     load_wb_valid,
    input  logic [4:0]               load_wb_index,
    input  logic                     branch_resolved,
    input  logic                     branch_taken,
    input  logic                     recovery_trigger,
    output logic                     redirect,
    output logic                     illegal_instr,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {
        RUN,
        BR_WAIT
    } state_t;

    state_t          state;
    logic [31:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [31:0]     pending;
    logic [7:0]      br_cnt;

    logic [31:0]     head;
    logic [4:0]      rs, rt, rd;
    logic [4:0]      s1, s2, dst;
    logic            legal, dec_branch, dec_load;
    logic            s1_rdy, s2_rdy;
    logic            empty, full;
    logic            do_issue, do_drop, pop, push, taken_flush;
    logic [31:0]     pending_nxt;

    assign head  = mem[rd_ptr];
    assign rs    = head[25:21];
    assign rt    = head[20:16];
    assign rd    = head[15:11];
    assign empty = (fifo_count == '0);
    assign full  = (fifo_count == CW'(DEPTH));
    assign fetch_ready = !full;

    always_comb begin
        legal      = 1'b0;
        dec_branch = 1'b0;
        dec_load   = 1'b0;
        s1         = rs;
        s2         = rt;
        dst        = rd;
        case (head[31:26])
            6'h00: legal = 1'b1;
            6'h08: begin
                legal = 1'b1;
                s2    = rs;
                dst   = rt;
            end
            6'h04, 6'h05: begin
                legal      = 1'b1;
                dec_branch = 1'b1;
                dst        = '0;
            end
            6'h23: begin
                legal    = 1'b1;
                dec_load = 1'b1;
                s2       = rs;
                dst      = rt;
            end
            default: legal = 1'b0;
        endcase
    end

    // A writeback landing this cycle bypasses the scoreboard bit.
    assign s1_rdy = (s1 == '0) || !pending[s1]
                 || (result_valid && result_index == {1'b0, s1})
                 || (load_wb_valid && load_wb_index == s1);
    assign s2_rdy = (s2 == '0) || !pending[s2]
                 || (result_valid && result_index == {1'b0, s2})
                 || (load_wb_valid && load_wb_index == s2);

    assign do_issue    = (state == RUN) && !empty && legal && s1_rdy && s2_rdy;
    assign do_drop     = (state == RUN) && !empty && !legal;
    assign pop         = do_issue || do_drop;
    assign taken_flush = (state == BR_WAIT) && branch_resolved && branch_taken;
    assign push        = fetch_valid && !full && !recovery_trigger && !taken_flush;

    // Clears first, then the dispatch set, so a same-cycle set wins.
    always_comb begin
        pending_nxt = pending;
        if (result_valid && !result_index[5])
            pending_nxt[result_index[4:0]] = 1'b0;
        if (load_wb_valid)
            pending_nxt[load_wb_index] = 1'b0;
        if (do_issue && dst != '0)
            pending_nxt[dst] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= fetch_instr;
    end

    always_ff @(posedge clk) begin
        // Recovery has the same effect as reset on every piece of state.
        if (!rst_n || recovery_trigger) begin
            state         <= RUN;
            br_cnt        <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_count    <= '0;
            pending       <= '0;
            instr_out     <= '0;
            instr_valid   <= 1'b0;
            src1_index    <= '0;
            src2_index    <= '0;
            dest_index    <= '0;
            src1_valid    <= 1'b0;
            src2_valid    <= 1'b0;
            is_branch     <= 1'b0;
            is_load       <= 1'b0;
            redirect      <= 1'b0;
            illegal_instr <= 1'b0;
        end else begin
            instr_valid   <= do_issue;
            instr_out     <= do_issue ? head : '0;
            src1_index    <= do_issue ? {1'b0, s1} : '0;
            src2_index    <= do_issue ? {1'b0, s2} : '0;
            dest_index    <= do_issue ? {1'b0, dst} : '0;
            src1_valid    <= do_issue;
            src2_valid    <= do_issue;
            is_branch     <= do_issue && dec_branch;
            is_load       <= do_issue && dec_load;
            illegal_instr <= do_drop;
            redirect      <= taken_flush;
            pending       <= pending_nxt;

            if (taken_flush) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_count <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   fifo_count <= fifo_count + 1'b1;
                    2'b01:   fifo_count <= fifo_count - 1'b1;
                    default: fifo_count <= fifo_count;
                endcase
            end

            // The hold lasts BR_TIMEOUT cycles: release on the edge where
            // the counter would reach BR_TIMEOUT.
            case (state)
                RUN: begin
                    if (do_issue && dec_branch) begin
                        state  <= BR_WAIT;
                        br_cnt <= '0;
                    end
                end
                BR_WAIT: begin
                    br_cnt <= br_cnt + 1'b1;
                    if (branch_resolved
                        || ({1'b0, br_cnt} + 9'd1) >= 9'(BR_TIMEOUT))
                        state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_fast_dispatch.sv
// Scoreboard testbench for fast_dispatch. A driver applies directed and
// random stimulus on the falling edge and steps a queue-based reference
// model, pushing the expected per-cycle status and expected dispatch records.
// A monitor samples just after each rising edge, pops the queues and compares.
module tb_fast_dispatch;

    localparam int DEPTH      = 8;
    localparam int BR_TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] fetch_instr = '0;
    logic        fetch_valid = 1'b0;
    logic        fetch_ready;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic [5:0]  src1_index, src2_index, dest_index;
    logic        src1_valid, src2_valid, is_branch, is_load;
    logic        result_valid = 1'b0;
    logic [5:0]  result_index = '0;
    logic        load_wb_valid = 1'b0;
    logic [4:0]  load_wb_index = '0;
    logic        branch_resolved = 1'b0;
    logic        branch_taken = 1'b0;
    logic        recovery_trigger = 1'b0;
    logic        redirect, illegal_instr;
    logic [3:0]  fifo_count;

    always #5 clk = ~clk;

    fast_dispatch #(.DEPTH(DEPTH), .BR_TIMEOUT(BR_TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_instr(fetch_instr), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
        .instr_out(instr_out), .instr_valid(instr_valid),
        .src1_index(src1_index), .src2_index(src2_index), .dest_index(dest_index),
        .src1_valid(src1_valid), .src2_valid(src2_valid),
        .is_branch(is_branch), .is_load(is_load),
        .result_valid(result_valid), .result_index(result_index),
        .load_wb_valid(load_wb_valid), .load_wb_index(load_wb_index),
        .branch_resolved(branch_resolved), .branch_taken(branch_taken),
        .recovery_trigger(recovery_trigger),
        .redirect(redirect), .illegal_instr(illegal_instr),
        .fifo_count(fifo_count)
    );

    typedef struct {
        logic [31:0] instr;
        logic [5:0]  s1, s2, d;
        logic        b, l;
    } disp_t;

    typedef struct {
        logic rst;
        logic iv;
        logic redir;
        logic ill;
        int   cnt;
        logic fr;
    } stat_t;

    disp_t       dq[$];
    stat_t       sq[$];
    int          total = 0;
    int          bad = 0;

    // Reference model state: FIFO contents, pending registers, hold cycles left.
    logic [31:0] mq[$];
    bit          mpend[32];
    int          hold = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // 0 illegal, 1 R-type, 2 addi, 3 branch, 4 load
    function automatic int kind(input logic [31:0] w);
        case (w[31:26])
            6'h00:        return 1;
            6'h08:        return 2;
            6'h04, 6'h05: return 3;
            6'h23:        return 4;
            default:      return 0;
        endcase
    endfunction

    function automatic bit rdy(input logic [4:0] r, input bit rv, input logic [5:0] ri,
                               input bit lv, input logic [4:0] li);
        return (r == 0) || !mpend[r] || (rv && ri == {1'b0, r}) || (lv && li == r);
    endfunction

    task automatic model_step(input bit rstv, input bit rec, input bit fv, input logic [31:0] fi,
                              input bit rv, input logic [5:0] ri, input bit lv,
                              input logic [4:0] li, input bit brr, input bit brt);
        stat_t s;
        disp_t d;
        bit disp = 0, ill = 0, taken = 0, fr;
        int k = 0;
        logic [31:0] w;
        logic [4:0] a, b, t;
        d = '{instr: '0, s1: '0, s2: '0, d: '0, b: 1'b0, l: 1'b0};
        fr = (mq.size() < DEPTH);
        if (!rstv || rec) begin
            mq.delete();
            foreach (mpend[i]) mpend[i] = 0;
            hold = 0;
        end else begin
            taken = (hold > 0) && brr && brt;
            if (hold == 0 && mq.size() > 0) begin
                w = mq[0];
                k = kind(w);
                if (k == 0) begin
                    ill = 1;
                    void'(mq.pop_front());
                end else begin
                    a = w[25:21];
                    b = (k == 2 || k == 4) ? w[25:21] : w[20:16];
                    t = (k == 1) ? w[15:11] : (k == 3) ? 5'd0 : w[20:16];
                    if (rdy(a, rv, ri, lv, li) && rdy(b, rv, ri, lv, li)) begin
                        disp = 1;
                        void'(mq.pop_front());
                        d = '{instr: w, s1: {1'b0, a}, s2: {1'b0, b}, d: {1'b0, t},
                              b: (k == 3), l: (k == 4)};
                    end
                end
            end
            if (rv && ri < 32) mpend[ri[4:0]] = 0;
            if (lv) mpend[li] = 0;
            if (disp && d.d != 0) mpend[d.d[4:0]] = 1;
            if (hold > 0) begin
                if (brr) begin
                    hold = 0;
                    if (brt) mq.delete();
                end else begin
                    hold--;
                end
            end else if (disp && k == 3) begin
                hold = BR_TIMEOUT;
            end
            if (fv && fr && !taken) mq.push_back(fi);
        end
        s = '{rst: !rstv, iv: disp, redir: taken, ill: ill, cnt: mq.size(),
              fr: (mq.size() < DEPTH)};
        sq.push_back(s);
        if (disp) dq.push_back(d);
    endtask

    task automatic cyc(input bit rstv, input bit rec, input bit fv, input logic [31:0] fi,
                       input bit rv, input logic [5:0] ri, input bit lv, input logic [4:0] li,
                       input bit brr, input bit brt);
        @(negedge clk);
        rst_n = rstv; recovery_trigger = rec;
        fetch_valid = fv; fetch_instr = fi;
        result_valid = rv; result_index = ri;
        load_wb_valid = lv; load_wb_index = li;
        branch_resolved = brr; branch_taken = brt;
        model_step(rstv, rec, fv, fi, rv, ri, lv, li, brr, brt);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1, 0, 0, '0, 0, '0, 0, '0, 0, 0);
    endtask

    task automatic push(input logic [31:0] w);
        cyc(1, 0, 1, w, 0, '0, 0, '0, 0, 0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] op;
        case ($urandom_range(0, 9))
            0, 1, 2: op = 6'h00;
            3, 4:    op = 6'h08;
            5:       op = 6'h04;
            6:       op = 6'h05;
            7:       op = 6'h23;
            8:       op = 6'h3F;
            default: op = 6'($urandom_range(0, 63));
        endcase
        return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 11'($urandom)};
    endfunction

    // Monitor
    initial begin
        stat_t s;
        disp_t d;
        forever begin
            @(posedge clk);
            #1;
            if (sq.size() > 0) begin
                s = sq.pop_front();
                if (s.rst) begin
                    chk("rst_instr_out", instr_out, 32'd0);
                    chk("rst_indices", {14'd0, src1_index, src2_index, dest_index}, 32'd0);
                    chk("rst_flags", {24'd0, instr_valid, src1_valid, src2_valid, is_branch,
                                      is_load, redirect, illegal_instr, 1'b0}, 32'd0);
                    chk("rst_fifo_count", fifo_count, 32'd0);
                    chk("rst_fetch_ready", fetch_ready, 32'd1);
                end else begin
                    chk("instr_valid", instr_valid, s.iv);
                    chk("redirect", redirect, s.redir);
                    chk("illegal_instr", illegal_instr, s.ill);
                    chk("fifo_count", fifo_count, s.cnt);
                    chk("fetch_ready", fetch_ready, s.fr);
                    if (s.iv) begin
                        d = dq.pop_front();
                        if (instr_valid) begin
                            chk("instr_out", instr_out, d.instr);
                            chk("src1_index", src1_index, d.s1);
                            chk("src2_index", src2_index, d.s2);
                            chk("dest_index", dest_index, d.d);
                            chk("is_branch", is_branch, d.b);
                            chk("is_load", is_load, d.l);
                            chk("src_valids", {src1_valid, src2_valid}, 32'd3);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Driver
    initial begin
        bit rstv, rec, fv, rv, lv, brr, brt;
        logic [5:0] ri;
        logic [4:0] li;

        cyc(0, 0, 0, '0, 0, '0, 0, '0, 0, 0);
        cyc(0, 0, 0, '0, 0, '0, 0, '0, 0, 0);

        // add r3,r1,r2 into an empty FIFO
        push(32'h00221820);
        idle(3);
        // add r3 then dependent sub r4,r3,r1; released by writeback of r3
        push(32'h00221820);
        push(32'h00612022);
        idle(4);
        cyc(1, 0, 0, '0, 1, 6'd3, 0, '0, 0, 0);
        idle(2);
        // beq r1,r2 followed by adds, resolved taken
        push(32'h10220000);
        repeat (3) push(32'h00222820);
        idle(4);
        cyc(1, 0, 0, '0, 0, '0, 0, '0, 1, 1);
        idle(3);
        // beq never resolved: timeout releases the hold
        push(32'h10220000);
        push(32'h00222820);
        idle(25);
        // fill behind a blocked head, then recovery
        push(32'h00223020);
        repeat (DEPTH + 2) push(32'h00C13820);
        idle(2);
        cyc(1, 1, 1, 32'h00221820, 0, '0, 0, '0, 0, 0);
        idle(2);
        // illegal opcode followed by a legal add
        push(32'hFC000000);
        push(32'h00221820);
        idle(4);
        // reset while content is queued
        push(32'h00221820);
        push(32'h00222820);
        cyc(0, 0, 1, 32'h00223020, 0, '0, 0, '0, 0, 0);
        idle(3);

        for (int i = 0; i < 3000; i++) begin
            rstv = !($urandom_range(0, 599) == 0);
            rec  = ($urandom_range(0, 199) == 0);
            fv   = ($urandom_range(0, 99) < 60);
            rv   = ($urandom_range(0, 99) < 35);
            ri   = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(32, 63))
                                               : 6'($urandom_range(0, 7));
            lv   = ($urandom_range(0, 99) < 20);
            li   = 5'($urandom_range(0, 7));
            brr  = ($urandom_range(0, 99) < 8);
            brt  = ($urandom_range(0, 1) == 1);
            cyc(rstv, rec, fv, rand_instr(), rv, ri, lv, li, brr, brt);
        end
        idle(3);
        @(negedge clk);
        chk("queues_drained", sq.size() + dq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fast_dispatch.md
Name: fast_dispatch

Overview:
In-order decode/dispatch stage directly upstream of fast_core. Buffers fetched instructions in a FIFO, decodes the MIPS-style fields into source/destination indices, and tracks register hazards with a 32-entry pending scoreboard. Issues one instruction per cycle with operands marked ready. Holds dispatch while a branch is in flight, and flushes on a taken branch or on recovery.

Parameters:
DEPTH, 8, instruction FIFO entries (power of two, >= 2)
BR_TIMEOUT, 15, cycles to wait for branch_resolved before releasing the branch hold (max 255)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
fetch_instr  in  32  fetched instruction word
fetch_valid  in  1  fetch_instr valid
fetch_ready  out  1  FIFO can accept (= !full)
instr_out  out  32  dispatched instruction (to core instr_in)
instr_valid  out  1  one-cycle dispatch pulse
src1_index  out  6  {1'b0, source 1 reg}
src2_index  out  6  {1'b0, source 2 reg}
dest_index  out  6  {1'b0, dest reg}; 0 for branches
src1_valid  out  1  source 1 ready
src2_valid  out  1  source 2 ready
is_branch  out  1  opcode 0x04/0x05
is_load  out  1  opcode 0x23
result_valid  in  1  core writeback pulse
result_index  in  6  core writeback index
load_wb_valid  in  1  load unit writeback pulse
load_wb_index  in  5  load writeback register
branch_resolved  in  1  core branch outcome valid
branch_taken  in  1  branch outcome
recovery_trigger  in  1  global flush
redirect  out  1  one-cycle pulse: taken branch, FIFO flushed
illegal_instr  out  1  one-cycle pulse: unsupported opcode dropped
fifo_count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (rst_n=0 at posedge): FIFO empty, fifo_count=0, scoreboard clear, FSM=RUN, timeout counter=0. All outputs 0 except fetch_ready=1. Reset mid-operation discards all content.
- Push when fetch_valid && fetch_ready. fetch_ready depends only on full, so no push occurs while full, even if a pop happens in the same cycle. Push and pop in the same cycle leave the count unchanged. Pointers wrap modulo DEPTH.
- Decode at the FIFO head (rs=[25:21], rt=[20:16], rd=[15:11]):
  - 0x00 R-type: src1=rs, src2=rt, dest=rd.
  - 0x08 addi: src1=rs, src2=rs, dest=rt.
  - 0x04/0x05 branch: src1=rs, src2=rt, dest=0, is_branch=1.
  - 0x23 load: src1=rs, src2=rs, dest=rt, is_load=1.
  - Any other opcode: popped without dispatch and illegal_instr pulses.
- Ready rule: a source is ready if its index is 0, or pending[idx]==0, or the same-cycle result_valid && result_index==idx, or the same-cycle load_wb_valid && load_wb_index==idx.
- Dispatch in RUN only, when the FIFO is non-empty and both sources are ready. Strictly in order: a blocked head blocks everything behind it.
- All outputs are registered. A head present in cycle N dispatches with instr_valid=1 in cycle N+1. A word pushed in cycle N dispatches at the earliest in cycle N+2. src1_valid and src2_valid are 1 on every dispatch.
- Scoreboard: a dispatch with dest!=0 sets pending[dest]. result_valid clears pending[result_index[4:0]], and only when result_index<32. load_wb_valid clears pending[load_wb_index]. If set and clear hit the same index in the same cycle, set wins. pending[0] is never set.
- FSM:
  - RUN → BR_WAIT on dispatch of a branch; the counter loads 0.
  - BR_WAIT: no dispatch; the counter increments each cycle.
  - BR_WAIT → RUN on branch_resolved, or when the counter reaches BR_TIMEOUT (the core silently drops branches with unavailable operands).
  - branch_resolved && branch_taken in BR_WAIT: FIFO flushed, redirect pulses next cycle, scoreboard kept. A fetch push in that same cycle is discarded.
  - branch_resolved while in RUN is ignored.
- recovery_trigger (highest priority after reset): FIFO flushed, scoreboard cleared, FSM→RUN, instr_valid=0 next cycle, same-cycle push discarded, no redirect.

Test Plan:
- Push add r3,r1,r2 (0x00221820) into an empty FIFO → instr_valid in cycle 2, src1=1, src2=2, dest=3, pending[3]=1.
- add r3 then sub r4,r3,r1 back-to-back → sub is held until result_valid with result_index=3. With the bypass, sub dispatches in the cycle after that writeback.
- beq r1,r2 then 3 adds → no add dispatches until branch_resolved. With branch_taken=1: redirect pulses, fifo_count=0, adds never dispatch.
- beq with no branch_resolved → dispatch resumes exactly BR_TIMEOUT=15 cycles after the branch dispatch.
- Push DEPTH+2 words with the head blocked → fetch_ready=0 at count=8, extra words not accepted, count stays 8. Then recovery_trigger → count=0, all pending cleared.
- Opcode 0x3F → illegal_instr pulses, no instr_valid, the next instruction dispatches normally. Assert rst_n=0 mid-stream → all outputs 0 at the next edge.
